mem_ctrl_mc: RTL and testbench



---
 rtl/mem_ctrl_mc.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_ctrl_mc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_mc.sv
// mem_ctrl_mc: multi-channel cache-line memory controller.
// Requesters issue word-wide read/write transactions; the controller arbitrates
// a single winner, then moves a full host line (FILL_COUNT words) between the
// requester beat bus and the host line bus.
// Build option: define MEM_CTRL_MC_RR_EN for round-robin arbitration; when it is
// undefined, arbitration is fixed priority (lowest channel index wins).
module mem_ctrl_mc #(
    parameter int WORD_SIZE     = 64,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64,
    parameter int NUM_CH        = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            host_init,
    input  logic                            host_rd_ready,
    input  logic                            host_wr_ready,
    input  logic [2*NUM_CH-1:0]             ch_op,
    input  logic [ADDR_BITCOUNT*NUM_CH-1:0] ch_raw_address,
    input  logic [ADDR_BITCOUNT-1:0]        address_offset,
    input  logic [WORD_SIZE*NUM_CH-1:0]     ch_wdata,
    input  logic [CL_SIZE_WIDTH-1:0]        host_data_bus_read_in,
    output logic [CL_SIZE_WIDTH-1:0]        host_data_bus_write_out,
    output logic [WORD_SIZE-1:0]            common_data_bus_write_out,
    output logic [ADDR_BITCOUNT-1:0]        corrected_address,
    output logic [NUM_CH-1:0]               ch_grant,
    output logic                            ready,
    output logic                            tx_done,
    output logic                            rd_valid,
    output logic                            wr_accept,
    output logic                            host_re,
    output logic                            host_we,
    output logic                            host_rgo,
    output logic                            host_wgo
);

    localparam int FILL_COUNT = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int BEAT_W     = (FILL_COUNT > 1) ? $clog2(FILL_COUNT) : 1;
    localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FILL_COUNT - 1);

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RD_HOST   = 3'd2,
        ST_RD_DRAIN  = 3'd3,
        ST_WR_FILL   = 3'd4,
        ST_WR_BUBBLE = 3'd5,
        ST_WR_HOST   = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [CL_SIZE_WIDTH-1:0] line_q, line_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [NUM_CH-1:0]        grant_q, grant_d;
    logic [ADDR_BITCOUNT-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]         win_q, win_d;
`ifdef MEM_CTRL_MC_RR_EN
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
`endif

    logic [NUM_CH-1:0]        req_s;
    logic                     req_found_s;
    logic [IDX_W-1:0]         win_idx_s;
    logic [NUM_CH-1:0]        win_onehot_s;
    logic [ADDR_BITCOUNT-1:0] sel_addr_s;
    logic                     sel_wr_s;
    logic [WORD_SIZE-1:0]     own_wdata_s;
    logic [WORD_SIZE-1:0]     rd_word_s;

    logic                     ready_s, tx_done_s, rd_valid_s, wr_accept_s;
    logic                     host_re_s, host_we_s, host_rgo_s, host_wgo_s;
    logic [WORD_SIZE-1:0]     rd_data_s;

    // Request decode: op 01 (read) and 11 (write) both have bit 0 set; 00/10 are idle.
    always_comb begin
        req_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            req_s[i] = ch_op[2*i];
        end
    end

    // Arbiter: pick the first requesting channel in search order.
    always_comb begin
        int cand;
        req_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        cand        = 0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef MEM_CTRL_MC_RR_EN
            cand = (int'(rr_ptr_q) + 1 + k) % NUM_CH;
`else
            cand = k;
`endif
            if (!req_found_s && req_s[cand]) begin
                req_found_s = 1'b1;
                win_idx_s   = IDX_W'(cand);
            end else begin
                req_found_s = req_found_s;
            end
        end
    end

    // Winner-side data selection: one-hot grant, corrected address, op, and owner beat data.
    always_comb begin
        win_onehot_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            win_onehot_s[i] = (win_idx_s == IDX_W'(i));
        end
        sel_addr_s  = ch_raw_address[int'(win_idx_s)*ADDR_BITCOUNT +: ADDR_BITCOUNT] + address_offset;
        sel_wr_s    = ch_op[int'(win_idx_s)*2 + 1];
        own_wdata_s = ch_wdata[int'(win_q)*WORD_SIZE +: WORD_SIZE];
        rd_word_s   = line_q[int'(beat_q)*WORD_SIZE +: WORD_SIZE];
    end

    // Next-state and strobe decode for the transaction FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        beat_d      = beat_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        win_d       = win_q;
`ifdef MEM_CTRL_MC_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        ready_s     = 1'b0;
        tx_done_s   = 1'b0;
        rd_valid_s  = 1'b0;
        wr_accept_s = 1'b0;
        host_re_s   = 1'b0;
        host_we_s   = 1'b0;
        host_rgo_s  = 1'b0;
        host_wgo_s  = 1'b0;
        rd_data_s   = {WORD_SIZE{1'b0}};

        case (state_q)
            ST_STARTUP: begin
                if (host_init) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STARTUP;
                end
            end
            ST_IDLE: begin
                ready_s = 1'b1;
                if (req_found_s) begin
                    win_d   = win_idx_s;
                    grant_d = win_onehot_s;
                    addr_d  = sel_addr_s;
                    beat_d  = {BEAT_W{1'b0}};
`ifdef MEM_CTRL_MC_RR_EN
                    rr_ptr_d = win_idx_s;
`endif
                    state_d = sel_wr_s ? ST_WR_FILL : ST_RD_HOST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_HOST: begin
                ready_s    = 1'b1;
                host_rgo_s = 1'b1;
                if (host_rd_ready) begin
                    host_re_s = 1'b1;
                    line_d    = host_data_bus_read_in;
                    beat_d    = {BEAT_W{1'b0}};
                    state_d   = ST_RD_DRAIN;
                end else begin
                    state_d   = ST_RD_HOST;
                end
            end
            ST_RD_DRAIN: begin
                ready_s    = 1'b1;
                rd_valid_s = 1'b1;
                rd_data_s  = rd_word_s;
                if (beat_q == LAST_BEAT) begin
                    tx_done_s = 1'b1;
                    beat_d    = {BEAT_W{1'b0}};
                    grant_d   = {NUM_CH{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    beat_d    = beat_q + 1'b1;
                end
            end
            ST_WR_FILL: begin
                ready_s     = 1'b1;
                wr_accept_s = 1'b1;
                line_d[int'(beat_q)*WORD_SIZE +: WORD_SIZE] = own_wdata_s;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = ST_WR_BUBBLE;
                end else begin
                    beat_d  = beat_q + 1'b1;
                end
            end
            ST_WR_BUBBLE: begin
                // One quiet cycle between the last accepted beat and the host write.
                ready_s = 1'b1;
                state_d = ST_WR_HOST;
            end
            ST_WR_HOST: begin
                ready_s    = 1'b1;
                host_wgo_s = 1'b1;
                if (host_wr_ready) begin
                    host_we_s = 1'b1;
                    tx_done_s = 1'b1;
                    grant_d   = {NUM_CH{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_WR_HOST;
                end
            end
            default: begin
                state_d = ST_STARTUP;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_STARTUP;
            line_q   <= {CL_SIZE_WIDTH{1'b0}};
            beat_q   <= {BEAT_W{1'b0}};
            grant_q  <= {NUM_CH{1'b0}};
            addr_q   <= {ADDR_BITCOUNT{1'b0}};
            win_q    <= {IDX_W{1'b0}};
`ifdef MEM_CTRL_MC_RR_EN
            rr_ptr_q <= IDX_W'(NUM_CH - 1);
`endif
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            win_q    <= win_d;
`ifdef MEM_CTRL_MC_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // Outputs are forced low while reset is asserted, even before the first edge.
    assign host_data_bus_write_out   = rst ? {CL_SIZE_WIDTH{1'b0}} : line_q;
    assign common_data_bus_write_out = rst ? {WORD_SIZE{1'b0}} : rd_data_s;
    assign corrected_address         = rst ? {ADDR_BITCOUNT{1'b0}} : addr_q;
    assign ch_grant                  = rst ? {NUM_CH{1'b0}} : grant_q;
    assign ready                     = ~rst & ready_s;
    assign tx_done                   = ~rst & tx_done_s;
    assign rd_valid                  = ~rst & rd_valid_s;
    assign wr_accept                 = ~rst & wr_accept_s;
    assign host_re                   = ~rst & host_re_s;
    assign host_we                   = ~rst & host_we_s;
    assign host_rgo                  = ~rst & host_rgo_s;
    assign host_wgo                  = ~rst & host_wgo_s;

endmodule

// File: tb/tb_mem_ctrl_mc.sv
// tb_mem_ctrl_mc: directed self-checking bench for mem_ctrl_mc
// (WORD_SIZE=64, CL_SIZE_WIDTH=256, NUM_CH=2). A transaction-level model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_mem_ctrl_mc;

    localparam int WS  = 64;
    localparam int CL  = 256;
    localparam int AW  = 64;
    localparam int NCH = 2;
    localparam int FC  = CL / WS;
`ifdef MEM_CTRL_MC_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            host_init = 1'b0;
    logic            host_rd_ready = 1'b0;
    logic            host_wr_ready = 1'b0;
    logic [2*NCH-1:0]  ch_op = '0;
    logic [AW*NCH-1:0] ch_raw_address = '0;
    logic [AW-1:0]     address_offset = '0;
    logic [WS*NCH-1:0] ch_wdata = '0;
    logic [CL-1:0]     host_data_bus_read_in = '0;
    logic [CL-1:0]     host_data_bus_write_out;
    logic [WS-1:0]     common_data_bus_write_out;
    logic [AW-1:0]     corrected_address;
    logic [NCH-1:0]    ch_grant;
    logic ready, tx_done, rd_valid, wr_accept, host_re, host_we, host_rgo, host_wgo;

    int n_checks = 0;
    int n_err    = 0;

    mem_ctrl_mc #(.WORD_SIZE(WS), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .host_init(host_init),
        .host_rd_ready(host_rd_ready), .host_wr_ready(host_wr_ready),
        .ch_op(ch_op), .ch_raw_address(ch_raw_address), .address_offset(address_offset),
        .ch_wdata(ch_wdata), .host_data_bus_read_in(host_data_bus_read_in),
        .host_data_bus_write_out(host_data_bus_write_out),
        .common_data_bus_write_out(common_data_bus_write_out),
        .corrected_address(corrected_address), .ch_grant(ch_grant),
        .ready(ready), .tx_done(tx_done), .rd_valid(rd_valid), .wr_accept(wr_accept),
        .host_re(host_re), .host_we(host_we), .host_rgo(host_rgo), .host_wgo(host_wgo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit            m_up = 1'b0;       // host link brought up since last reset
    bit            m_busy = 1'b0;     // a transaction owns the controller
    int            m_owner = 0;
    int            m_last = NCH - 1;  // most recent winner
    logic [AW-1:0] m_addr = '0;
    logic [CL-1:0] m_line = '0;
    bit            m_rd_wait = 1'b0;  // waiting for the host read line
    logic [WS-1:0] drain_q[$];        // words still to hand to the reader
    int            fill_left = 0;
    int            fill_idx = 0;
    bit            m_bubble = 1'b0;
    bit            m_wr_wait = 1'b0;  // waiting for the host to take the line

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin : compare
        bit            e_rdv, e_txd;
        logic [WS-1:0] e_word;
        int            w;
        e_rdv  = (drain_q.size() > 0);
        e_word = e_rdv ? drain_q[0] : '0;
        e_txd  = (drain_q.size() == 1) || (m_wr_wait && host_wr_ready);
        if (rst) begin
            chk("cyc_rst_all", 256'({ready, tx_done, rd_valid, wr_accept, host_re, host_we,
                host_rgo, host_wgo, ch_grant}), 256'(0));
            chk("cyc_rst_bus", host_data_bus_write_out | 256'(common_data_bus_write_out)
                | 256'(corrected_address), 256'(0));
        end else begin
            chk("cyc_ready",    256'(ready),     256'(m_up));
            chk("cyc_grant",    256'(ch_grant),  256'(m_busy ? (1 << m_owner) : 0));
            chk("cyc_addr",     256'(corrected_address), 256'(m_addr));
            chk("cyc_rgo",      256'(host_rgo),  256'(m_rd_wait));
            chk("cyc_re",       256'(host_re),   256'(m_rd_wait && host_rd_ready));
            chk("cyc_rd_valid", 256'(rd_valid),  256'(e_rdv));
            chk("cyc_rd_word",  256'(common_data_bus_write_out), 256'(e_word));
            chk("cyc_tx_done",  256'(tx_done),   256'(e_txd));
            chk("cyc_wr_acc",   256'(wr_accept), 256'(fill_left > 0));
            chk("cyc_wgo",      256'(host_wgo),  256'(m_wr_wait));
            chk("cyc_we",       256'(host_we),   256'(m_wr_wait && host_wr_ready));
            chk("cyc_line",     host_data_bus_write_out, m_line);
        end
        // advance
        if (rst) begin
            m_up = 1'b0; m_busy = 1'b0; m_rd_wait = 1'b0; m_bubble = 1'b0; m_wr_wait = 1'b0;
            fill_left = 0; fill_idx = 0; m_line = '0; m_addr = '0; m_owner = 0;
            m_last = NCH - 1; drain_q.delete();
        end else if (!m_up) begin
            m_up = host_init;
        end else if (!m_busy) begin
            w = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = RR ? (m_last + 1 + k) % NCH : k;
                if (w < 0 && ch_op[2*c]) w = c;
            end
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_last = w;
                m_addr = ch_raw_address[w*AW +: AW] + address_offset;
                if (ch_op[2*w+1]) begin fill_left = FC; fill_idx = 0; end
                else m_rd_wait = 1'b1;
            end
        end else if (m_rd_wait) begin
            if (host_rd_ready) begin
                m_line = host_data_bus_read_in;
                for (int b = 0; b < FC; b++) drain_q.push_back(m_line[b*WS +: WS]);
                m_rd_wait = 1'b0;
            end
        end else if (drain_q.size() > 0) begin
            void'(drain_q.pop_front());
            if (drain_q.size() == 0) m_busy = 1'b0;
        end else if (fill_left > 0) begin
            m_line[fill_idx*WS +: WS] = ch_wdata[m_owner*WS +: WS];
            fill_idx++; fill_left--;
            if (fill_left == 0) m_bubble = 1'b1;
        end else if (m_bubble) begin
            m_bubble = 1'b0; m_wr_wait = 1'b1;
        end else if (m_wr_wait) begin
            if (host_wr_ready) begin m_wr_wait = 1'b0; m_busy = 1'b0; end
        end
    end

    // ---------------- stimulus ----------------
    logic          s_ready, s_txd, s_rdv, s_acc, s_re, s_we, s_rgo, s_wgo;
    logic [NCH-1:0] s_grant;
    logic [WS-1:0] s_word;
    logic [CL-1:0] s_hwo;
    logic [AW-1:0] s_addr;

    // Sample outputs mid-cycle, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        s_ready = ready; s_txd = tx_done; s_rdv = rd_valid; s_acc = wr_accept;
        s_re = host_re; s_we = host_we; s_rgo = host_rgo; s_wgo = host_wgo;
        s_grant = ch_grant; s_word = common_data_bus_write_out;
        s_hwo = host_data_bus_write_out; s_addr = corrected_address;
        @(posedge clk);
        #1;
    endtask

    logic [WS-1:0]  rd_log[$];
    int             acc_n, bubble_n, we_n, wgo_wait, tx_beat;
    bit             done_seen, we_with_tx;
    logic [NCH-1:0] first_grant;
    logic [CL-1:0]  we_line;
    logic [AW-1:0]  done_addr;

    task automatic run_txn(input logic [2*NCH-1:0] ops, input bit hold, input int rd_dly,
                           input int wr_dly, input logic [WS-1:0] wb0, input logic [WS-1:0] wb1);
        int rgo_n, wgo_n;
        rd_log.delete();
        acc_n = 0; bubble_n = 0; we_n = 0; wgo_wait = 0; tx_beat = -1;
        done_seen = 1'b0; we_with_tx = 1'b0; first_grant = '0; we_line = '0; done_addr = '0;
        rgo_n = 0; wgo_n = 0;
        ch_op = ops;
        for (int n = 0; n < 40 && !done_seen; n++) begin
            host_rd_ready = (rgo_n >= rd_dly);
            host_wr_ready = (wgo_n >= wr_dly);
            ch_wdata = {wb1 + 64'(acc_n), wb0 + 64'(acc_n)};
            step();
            if (!hold) ch_op = '0;
            if (first_grant == '0) first_grant = s_grant;
            if (acc_n == FC && !s_wgo && !s_we && !s_rgo && !s_re && !s_acc) bubble_n++;
            if (s_rdv) rd_log.push_back(s_word);
            if (s_acc) acc_n++;
            if (s_rgo) rgo_n++;
            if (s_wgo) begin wgo_n++; if (!s_we) wgo_wait++; end
            if (s_we) begin we_n++; we_line = s_hwo; we_with_tx = s_txd; end
            if (s_txd) begin done_seen = 1'b1; tx_beat = rd_log.size(); done_addr = s_addr; end
        end
        host_rd_ready = 1'b0;
        host_wr_ready = 1'b0;
        chk("txn_completed", 256'(done_seen), 256'(1));
    endtask

    initial begin
        // Reset and startup gating
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin step(); chk("rst_ready", 256'(s_ready), 256'(0)); end
        rst = 1'b0; host_init = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); chk("startup_ready", 256'(s_ready), 256'(0)); end
        host_init = 1'b1;
        step();
        chk("init_edge_ready", 256'(s_ready), 256'(0));
        step();
        chk("init_ready", 256'(s_ready), 256'(1));

        // ch0 read, offset address, host line drained in four beats
        ch_raw_address = {64'h0000_0000_0000_0300, 64'h0000_0000_0000_0100};
        address_offset = 64'h0000_0000_0000_0040;
        host_data_bus_read_in = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        run_txn(4'b0001, 1'b0, 2, 0, 64'h0, 64'h0);
        chk("rd_addr",   256'(done_addr), 256'(64'h140));
        chk("rd_grant",  256'(first_grant), 256'(2'b01));
        chk("rd_beats",  256'(rd_log.size()), 256'(4));
        if (rd_log.size() == 4) begin
            chk("rd_beat0", 256'(rd_log[0]), 256'(64'hAAAA_AAAA_AAAA_AAAA));
            chk("rd_beat1", 256'(rd_log[1]), 256'(64'hBBBB_BBBB_BBBB_BBBB));
            chk("rd_beat2", 256'(rd_log[2]), 256'(64'hCCCC_CCCC_CCCC_CCCC));
            chk("rd_beat3", 256'(rd_log[3]), 256'(64'hDDDD_DDDD_DDDD_DDDD));
        end
        chk("rd_tx_on_4th", 256'(tx_beat), 256'(4));

        // ch1 write of beats 1..4 with the host ready
        run_txn(4'b1100, 1'b0, 0, 0, 64'h100, 64'h1);
        chk("wr_grant",   256'(first_grant), 256'(2'b10));
        chk("wr_accepts", 256'(acc_n), 256'(4));
        chk("wr_bubble",  256'(bubble_n), 256'(1));
        chk("wr_we_n",    256'(we_n), 256'(1));
        chk("wr_we_tx",   256'(we_with_tx), 256'(1));
        chk("wr_line",    we_line, {64'd4, 64'd3, 64'd2, 64'd1});
        chk("wr_addr",    256'(done_addr), 256'(64'h340));

        // Both channels reading continuously
        run_txn(4'b0101, 1'b1, 0, 0, 64'h0, 64'h0);
        chk("arb_grant0", 256'(first_grant), 256'(2'b01));
        run_txn(4'b0101, 1'b1, 0, 0, 64'h0, 64'h0);
        chk("arb_grant1", 256'(first_grant), 256'(RR ? 2'b10 : 2'b01));
        run_txn(4'b0101, 1'b1, 0, 0, 64'h0, 64'h0);
        chk("arb_grant2", 256'(first_grant), 256'(2'b01));
        ch_op = '0;
        step();

        // ch0 write with the host stalling ten cycles
        run_txn(4'b0011, 1'b0, 0, 10, 64'h10, 64'h900);
        chk("stall_wgo_wait", 256'(wgo_wait), 256'(10));
        chk("stall_we_n",     256'(we_n), 256'(1));
        chk("stall_line",     we_line, {64'h13, 64'h12, 64'h11, 64'h10});

        // Reset during the second drain beat abandons the read
        ch_raw_address = {64'h0000_0000_0000_0300, 64'h0000_0000_0000_0200};
        ch_op = 4'b0001; host_rd_ready = 1'b1;
        step();
        ch_op = '0;
        step();
        chk("abort_re", 256'(s_re), 256'(1));
        step();
        chk("abort_beat0", 256'(s_rdv), 256'(1));
        rst = 1'b1;
        step();
        chk("abort_rdv_in_rst", 256'(s_rdv), 256'(0));
        chk("abort_txd_in_rst", 256'(s_txd), 256'(0));
        rst = 1'b0; host_init = 1'b0; host_rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_quiet", 256'({s_rdv, s_txd, s_ready, s_grant, s_rgo}), 256'(0));
            chk("abort_line",  s_hwo, 256'(0));
            chk("abort_addr",  256'(s_addr), 256'(0));
        end
        host_init = 1'b1;
        step();
        step();
        chk("reinit_ready", 256'(s_ready), 256'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
